// File: rtl/i2s_tdm_tx.sv
`timescale 1ns/1ps
// I2S/TDM master transmitter: sclk/ws/sd generation from pclk, sample FIFO fed by a
// valid/ready stream, whole-frame admission, Philips/MSB/LSB alignment, 16/24/32-bit words.
module i2s_tdm_tx #(
  parameter int NUM_CH     = 2,
  parameter int WORD_W     = 32,
  parameter int SLOT_W     = 32,
  parameter int DIV        = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          pclk,
  input  logic                          preset,
  input  logic                          en,
  input  logic [1:0]                    standard,
  input  logic [1:0]                    word_size,
  input  logic [WORD_W-1:0]             din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          sclk,
  output logic                          ws,
  output logic                          sd,
  output logic                          frame_start,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int FRAME = NUM_CH * SLOT_W;
  localparam int PW    = $clog2(FRAME);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int WIW   = $clog2(WORD_W);

  // Stream handshake: a sample transfers on a pclk edge where din_valid && din_ready.
  logic [DW-1:0]     div_q, div_d;
  logic              sclk_q, sclk_d;
  logic              active_q, active_d;
  logic              started_q, started_d;
  logic [PW-1:0]     p_q, p_d;
  logic [1:0]        std_q, std_d;
  logic [1:0]        size_q, size_d;
  logic              admit_q, admit_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              ws_q, ws_d;
  logic              sd_q, sd_d;
  logic              fs_q, fs_d;
  logic              underrun_q, underrun_d;
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]     level_q, level_d;

  logic              push, pop, set_ur, clr_ur, hit;
  logic [PW-1:0]     p_now;
  logic [WORD_W-1:0] word_n;
  int                b_now, n_bits, idx, q_pos;

  assign din_ready = (level_q < LW'(FIFO_DEPTH));
  assign push      = din_valid && din_ready;

  always_comb begin
    div_d     = div_q;
    sclk_d    = sclk_q;
    active_d  = active_q | en;
    started_d = started_q;
    p_d       = p_q;
    std_d     = std_q;
    size_d    = size_q;
    admit_d   = admit_q;
    word_d    = word_q;
    ws_d      = ws_q;
    sd_d      = sd_q;
    fs_d      = 1'b0;
    set_ur    = 1'b0;
    clr_ur    = !en && !active_q;
    pop       = 1'b0;
    hit       = 1'b0;
    p_now     = '0;
    word_n    = word_q;
    b_now     = 0;
    n_bits    = 16;
    idx       = 0;
    q_pos     = 0;
    if (en || active_q) begin
      if (div_q == DW'(DIV - 1)) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
        if (sclk_q) begin
          // Falling edge: either stop at a frame boundary or advance the position.
          if (!en && (!started_q || p_q == PW'(FRAME - 1))) begin
            active_d  = 1'b0;
            started_d = 1'b0;
            p_d       = '0;
            ws_d      = 1'b0;
            sd_d      = 1'b0;
            clr_ur    = 1'b1;
          end else begin
            started_d = 1'b1;
            if (started_q && p_q != PW'(FRAME - 1)) p_now = p_q + 1'b1;
            p_d = p_now;
            if (p_now == '0) begin
              fs_d    = 1'b1;
              std_d   = (standard == 2'b11) ? 2'b01 : standard;
              size_d  = (word_size == 2'b11) ? 2'b10 : word_size;
              admit_d = (level_q >= LW'(NUM_CH));
              set_ur  = !admit_d;
            end
            b_now = int'(p_now) % SLOT_W;
            if (admit_d && b_now == 0) begin
              pop    = 1'b1;
              word_n = mem_q[rd_q];
            end
            word_d = word_n;
            case (size_d)
              2'b00:   n_bits = 16;
              2'b01:   n_bits = 24;
              default: n_bits = 32;
            endcase
            if (std_d == 2'b10) begin
              if (b_now >= SLOT_W - n_bits) begin
                hit = 1'b1;
                idx = n_bits - 1 - (b_now - (SLOT_W - n_bits));
              end
            end else if (b_now < n_bits) begin
              hit = 1'b1;
              idx = n_bits - 1 - b_now;
            end
            sd_d  = (admit_d && hit && idx >= 0 && idx < WORD_W) ? word_n[WIW'(idx)] : 1'b0;
            // Philips leads ws by one sclk relative to the slot data.
            q_pos = int'(p_now) + ((std_d == 2'b00) ? 1 : 0);
            if (q_pos >= FRAME) q_pos = q_pos - FRAME;
            ws_d  = (NUM_CH == 2) ? (q_pos >= SLOT_W) : (q_pos == 0);
          end
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
    underrun_d = set_ur | (underrun_q & ~clr_ur);
    wr_d       = wr_q + AW'(push);
    rd_d       = rd_q + AW'(pop);
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      div_q      <= '0;
      sclk_q     <= 1'b0;
      active_q   <= 1'b0;
      started_q  <= 1'b0;
      p_q        <= '0;
      std_q      <= 2'b01;
      size_q     <= 2'b10;
      admit_q    <= 1'b0;
      word_q     <= '0;
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
      fs_q       <= 1'b0;
      underrun_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
    end else begin
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      active_q   <= active_d;
      started_q  <= started_d;
      p_q        <= p_d;
      std_q      <= std_d;
      size_q     <= size_d;
      admit_q    <= admit_d;
      word_q     <= word_d;
      ws_q       <= ws_d;
      sd_q       <= sd_d;
      fs_q       <= fs_d;
      underrun_q <= underrun_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      level_q    <= level_d;
    end
  end

  always_ff @(posedge pclk) begin
    if (push && !preset) mem_q[wr_q] <= din;
  end

  assign sclk        = sclk_q;
  assign ws          = ws_q;
  assign sd          = sd_q;
  assign frame_start = fs_q;
  assign underrun    = underrun_q;
  assign fifo_level  = level_q;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
`timescale 1ns/1ps
// Bench for i2s_tdm_tx: a stereo instance driven by a vector table plus FIFO/reset
// sequences, and a 4-channel TDM instance for underrun and frame-sync behaviour.
module tb_i2s_tdm_tx;

  logic pclk = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;

  // stereo instance signals
  logic        s_en = 0, s_valid = 0, s_ready, s_sclk, s_ws, s_sd, s_fs, s_ur;
  logic [1:0]  s_std = 2'b01, s_wsz = 2'b00;
  logic [31:0] s_din = '0;
  logic [3:0]  s_level;
  // tdm instance signals
  logic        t_en = 0, t_valid = 0, t_ready, t_sclk, t_ws, t_sd, t_fs, t_ur;
  logic [1:0]  t_std = 2'b01, t_wsz = 2'b00;
  logic [31:0] t_din = '0;
  logic [3:0]  t_level;

  i2s_tdm_tx #(.NUM_CH(2), .WORD_W(32), .SLOT_W(32), .DIV(4), .FIFO_DEPTH(8)) u_st (
    .pclk(pclk), .preset(preset), .en(s_en), .standard(s_std), .word_size(s_wsz),
    .din(s_din), .din_valid(s_valid), .din_ready(s_ready), .sclk(s_sclk), .ws(s_ws),
    .sd(s_sd), .frame_start(s_fs), .underrun(s_ur), .fifo_level(s_level));

  i2s_tdm_tx #(.NUM_CH(4), .WORD_W(32), .SLOT_W(32), .DIV(4), .FIFO_DEPTH(8)) u_tdm (
    .pclk(pclk), .preset(preset), .en(t_en), .standard(t_std), .word_size(t_wsz),
    .din(t_din), .din_valid(t_valid), .din_ready(t_ready), .sclk(t_sclk), .ws(t_ws),
    .sd(t_sd), .frame_start(t_fs), .underrun(t_ur), .fifo_level(t_level));

  logic       sel = 1'b0;
  logic       c_sclk, c_ws, c_sd, c_fs, c_ur, c_ready;
  logic [3:0] c_level;
  assign c_sclk  = sel ? t_sclk  : s_sclk;
  assign c_ws    = sel ? t_ws    : s_ws;
  assign c_sd    = sel ? t_sd    : s_sd;
  assign c_fs    = sel ? t_fs    : s_fs;
  assign c_ur    = sel ? t_ur    : s_ur;
  assign c_ready = sel ? t_ready : s_ready;
  assign c_level = sel ? t_level : s_level;

  int checks = 0;
  int failures = 0;
  logic [127:0] cap_sd, cap_ws;
  int fs_cnt;

  typedef struct {
    logic [1:0]  std;
    logic [1:0]  wsz;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [63:0] exp_sd;
    logic [63:0] exp_ws;
  } vec_t;
  vec_t vecs[8];

  localparam logic [63:0] WS_MSB = 64'h00000000_FFFFFFFF;
  localparam logic [63:0] WS_PHI = 64'h00000001_FFFFFFFE;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    if (sel) begin t_din = d; t_valid = 1'b1; end
    else begin s_din = d; s_valid = 1'b1; end
    @(negedge pclk);
    t_valid = 1'b0;
    s_valid = 1'b0;
  endtask

  // Returns at the negedge right after the pclk edge where sclk went 1->0.
  task automatic wait_fall();
    logic prev;
    bit   ok;
    prev = c_sclk;
    ok   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge pclk);
      if (prev && !c_sclk) begin
        ok = 1'b1;
        break;
      end
      prev = c_sclk;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL sclk_fall_timeout: got no falling edge expected one within 40 pclk");
    end
  endtask

  task automatic capture(input int nf, input bit drop_en);
    cap_sd = '0;
    cap_ws = '0;
    fs_cnt = 0;
    for (int k = 0; k < nf; k++) begin
      wait_fall();
      cap_sd = {cap_sd[126:0], c_sd};
      cap_ws = {cap_ws[126:0], c_ws};
      fs_cnt += int'(c_fs);
      if (k == 0 && drop_en) begin
        if (sel) t_en = 1'b0; else s_en = 1'b0;
      end
    end
  endtask

  initial begin
    int fs_k;
    vecs[0] = '{2'b01, 2'b00, 32'h0000A5F0, 32'h00000F0F, 64'hA5F00000_0F0F0000, WS_MSB};
    vecs[1] = '{2'b00, 2'b00, 32'h0000A5F0, 32'h00000F0F, 64'hA5F00000_0F0F0000, WS_PHI};
    vecs[2] = '{2'b10, 2'b01, 32'h00123456, 32'h00ABCDEF, 64'h00123456_00ABCDEF, WS_MSB};
    vecs[3] = '{2'b01, 2'b01, 32'hFF123456, 32'h00800001, 64'h12345600_80000100, WS_MSB};
    vecs[4] = '{2'b01, 2'b10, 32'hDEADBEEF, 32'h80000001, 64'hDEADBEEF_80000001, WS_MSB};
    vecs[5] = '{2'b10, 2'b00, 32'hFFFFA5F0, 32'h00000001, 64'h0000A5F0_00000001, WS_MSB};
    vecs[6] = '{2'b11, 2'b11, 32'h12345678, 32'h9ABCDEF0, 64'h12345678_9ABCDEF0, WS_MSB};
    vecs[7] = '{2'b00, 2'b10, 32'h0000FFFF, 32'hF0000000, 64'h0000FFFF_F0000000, WS_PHI};

    // reset state of both instances
    repeat (3) @(negedge pclk);
    preset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk($sformatf("rst%0d_outs", s), {c_sclk, c_ws, c_sd, c_fs, c_ur}, 5'b0);
      chk($sformatf("rst%0d_level", s), c_level, 0);
      chk($sformatf("rst%0d_ready", s), c_ready, 1);
    end
    sel = 1'b0;
    @(negedge pclk);

    // table: one stereo frame per vector, en dropped after p=0 so the block idles after it
    for (int i = 0; i < 8; i++) begin
      s_std = vecs[i].std;
      s_wsz = vecs[i].wsz;
      push(vecs[i].d0);
      push(vecs[i].d1);
      s_en = 1'b1;
      if (i == 0) begin
        @(negedge pclk);
        @(negedge pclk);
        chk("ws_before_first_fall", c_ws, 0);
      end
      capture(64, 1'b1);
      chk($sformatf("v%0d_sd", i), cap_sd[63:0], vecs[i].exp_sd);
      chk($sformatf("v%0d_ws", i), cap_ws[63:0], vecs[i].exp_ws);
      chk($sformatf("v%0d_frame_start", i), fs_cnt, 1);
      chk($sformatf("v%0d_level", i), c_level, 0);
      wait_fall();
      chk($sformatf("v%0d_idle", i), {c_sclk, c_ws, c_sd, c_ur}, 4'b0);
    end

    // FIFO full, rejected push, then push coinciding with a pop
    s_std = 2'b01;
    s_wsz = 2'b00;
    for (int i = 0; i < 8; i++) push(32'h1000 + i);
    chk("full_level", c_level, 8);
    chk("full_ready", c_ready, 0);
    push(32'hDEAD);
    chk("full_reject", c_level, 8);
    s_en = 1'b1;
    wait_fall();
    chk("full_fs", c_fs, 1);
    chk("full_pop_level", c_level, 7);
    for (int k = 0; k < 31; k++) wait_fall();
    for (int i = 0; i < 20 && !c_sclk; i++) @(negedge pclk);
    chk("b_rise", c_sclk, 1);
    repeat (3) @(negedge pclk);
    push(32'h1008);
    chk("b_fall_sync", c_sclk, 0);
    chk("push_pop_level", c_level, 7);
    s_en = 1'b0;
    for (int k = 0; k < 32; k++) wait_fall();
    chk("after_drain_level", c_level, 7);
    s_en = 1'b1;
    capture(64, 1'b1);
    chk("order_sd", cap_sd[63:0], 64'h10020000_10030000);
    wait_fall();
    chk("order_level", c_level, 5);

    // reset mid-slot at p=40 with en held
    s_en = 1'b1;
    for (int k = 0; k < 41; k++) wait_fall();
    chk("c_ws_p40", c_ws, 1);
    @(negedge pclk);
    @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
    chk("c_rst_outs", {c_sclk, c_ws, c_sd, c_fs, c_ur}, 5'b0);
    chk("c_rst_level", c_level, 0);
    chk("c_rst_ready", c_ready, 1);
    fs_k = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge pclk);
      if (c_fs) begin
        fs_k = k;
        break;
      end
    end
    chk("c_restart_delay", fs_k, 8);
    chk("c_zero_frame_underrun", c_ur, 1);
    s_en = 1'b0;
    for (int k = 0; k < 64; k++) wait_fall();
    chk("c_underrun_cleared", c_ur, 0);
    chk("c_idle_outs", {c_sclk, c_ws, c_sd}, 3'b0);

    // TDM: one sample queued -> zero frame, then three more -> admitted frame
    sel = 1'b1;
    t_std = 2'b01;
    t_wsz = 2'b00;
    push(32'hC001);
    t_en = 1'b1;
    wait_fall();
    chk("d_fs", c_fs, 1);
    chk("d_underrun", c_ur, 1);
    chk("d_p0_ws_sd", {c_ws, c_sd}, 2'b10);
    chk("d_level1", c_level, 1);
    push(32'h0280);
    push(32'h7FFE);
    push(32'h1234);
    capture(127, 1'b0);
    chk("d_zero_sd", cap_sd, 0);
    chk("d_zero_ws", cap_ws, 0);
    chk("d_level4", c_level, 4);
    capture(128, 1'b1);
    chk("d_sd", cap_sd, 128'hC0010000_02800000_7FFE0000_12340000);
    chk("d_ws", cap_ws, {1'b1, 127'b0});
    chk("d_fs_count", fs_cnt, 1);
    chk("d_level0", c_level, 0);
    chk("d_underrun_sticky", c_ur, 1);
    wait_fall();
    chk("d_underrun_cleared", c_ur, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
